// File: rtl/ext_unit_arbiter_if.sv
// ext_unit_arbiter_if
//   Handshake bundle between the two extension requesters, the shared
//   extension unit and the result consumer.
//   master : requester/consumer side (drives request fields and res_ready_i)
//   slave  : arbiter side (drives ready strobes and the result register)
//   Signals: req{0,1}_valid_i/ready_o/data_i[15:0]/mode_i[2:0],
//            res_valid_o, res_ready_i, res_data_o[DATA_W-1:0], res_id_o, res_err_o
interface ext_unit_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [15:0]       req0_data_i;
  logic [2:0]        req0_mode_i;
  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [15:0]       req1_data_i;
  logic [2:0]        req1_mode_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [DATA_W-1:0] res_data_o;
  logic              res_id_o;
  logic              res_err_o;

  modport master (
    output req0_valid_i, req0_data_i, req0_mode_i,
    output req1_valid_i, req1_data_i, req1_mode_i,
    output res_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  res_valid_o, res_data_o, res_id_o, res_err_o
  );

  modport slave (
    input  req0_valid_i, req0_data_i, req0_mode_i,
    input  req1_valid_i, req1_data_i, req1_mode_i,
    input  res_ready_i,
    output req0_ready_o, req1_ready_o,
    output res_valid_o, res_data_o, res_id_o, res_err_o
  );
endinterface

// File: rtl/ext_unit_arbiter.sv
// ext_unit_arbiter
//   Round-robin arbiter sharing one immediate/load-data extension unit
//   between requester 0 (decode immediates) and requester 1 (load-data
//   alignment). The extended result is registered; a full register that is
//   being drained can be refilled in the same cycle.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : ext_unit_arbiter_if.slave (request/result handshakes)
//   gnt0_cnt_o, gnt1_cnt_o, err_cnt_o : saturating accept counters, present
//                                       only when EXT_ARB_STATS_EN is defined
// Modes: 0 SE16, 1 ZE16, 2 LUI, 3 SE8, 4 ZE8, 5-7 illegal (data 0, err 1).
module ext_unit_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter bit          FIRST_GNT = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef EXT_ARB_STATS_EN
  output logic [15:0] gnt0_cnt_o,
  output logic [15:0] gnt1_cnt_o,
  output logic [7:0]  err_cnt_o,
`endif
  ext_unit_arbiter_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state;
  logic                last_gnt;
  logic [DATA_W-1:0]   res_data;
  logic                res_id;
  logic                res_err;

  logic                can_accept;
  logic                gnt0;
  logic                gnt1;
  logic                acc0;
  logic                acc1;
  logic                accept;
  logic                sel_id;
  logic [15:0]         sel_data;
  logic [2:0]          sel_mode;
  logic [DATA_W+15:0]  lui_wide;
  logic [DATA_W-1:0]   ext_data;
  logic                ext_err;

  // Arbitration and handshake. last_gnt names the port served most recently,
  // so on a tie the other port wins.
  always_comb begin
    can_accept = (state == EMPTY) || bus.res_ready_i;
    gnt0       = bus.req0_valid_i && (!bus.req1_valid_i || last_gnt);
    gnt1       = bus.req1_valid_i && (!bus.req0_valid_i || !last_gnt);
    acc0       = !rst_i && can_accept && gnt0;
    acc1       = !rst_i && can_accept && gnt1;
    accept     = acc0 || acc1;
    sel_id     = acc1;
    sel_data   = acc1 ? bus.req1_data_i : bus.req0_data_i;
    sel_mode   = acc1 ? bus.req1_mode_i : bus.req0_mode_i;
  end

  assign bus.req0_ready_o = acc0;
  assign bus.req1_ready_o = acc1;

  // Extension datapath; widths are built bit-wise so any DATA_W >= 16 works.
  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    lui_wide = {{DATA_W{1'b0}}, sel_data} << 16;
    case (sel_mode)
      3'd0: begin
        ext_data[15:0] = sel_data;
        for (int unsigned i = 16; i < DATA_W; i++) ext_data[i] = sel_data[15];
      end
      3'd1: ext_data[15:0] = sel_data;
      3'd2: ext_data = lui_wide[DATA_W-1:0];
      3'd3: begin
        ext_data[7:0] = sel_data[7:0];
        for (int unsigned i = 8; i < DATA_W; i++) ext_data[i] = sel_data[7];
      end
      3'd4: ext_data[7:0] = sel_data[7:0];
      default: begin
        ext_data = '0;
        ext_err  = 1'b1;
      end
    endcase
  end

  // Result register FSM. An accept always (re)loads the register, which also
  // covers the FULL->FULL pass-through case.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= EMPTY;
      res_data <= '0;
      res_id   <= 1'b0;
      res_err  <= 1'b0;
      last_gnt <= !FIRST_GNT;
    end else if (accept) begin
      state    <= FULL;
      res_data <= ext_data;
      res_id   <= sel_id;
      res_err  <= ext_err;
      last_gnt <= sel_id;
    end else if (state == FULL && bus.res_ready_i) begin
      state    <= EMPTY;
    end
  end

  assign bus.res_valid_o = (state == FULL);
  assign bus.res_data_o  = res_data;
  assign bus.res_id_o    = res_id;
  assign bus.res_err_o   = res_err;

`ifdef EXT_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt0_cnt_o <= '0;
      gnt1_cnt_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      if (acc0 && gnt0_cnt_o != '1) gnt0_cnt_o <= gnt0_cnt_o + 16'd1;
      if (acc1 && gnt1_cnt_o != '1) gnt1_cnt_o <= gnt1_cnt_o + 16'd1;
      if (accept && ext_err && err_cnt_o != '1) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end
`endif

endmodule
